// File: rtl/la_rstseq_pkg.sv
// Shared definitions for the sequenced reset releaser.
// Holds the FSM encoding and the counter-width helper.
package la_rstseq_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    function automatic int cnt_width(input int delay, input int hold);
        int m;
        m = (delay > hold) ? delay : hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/la_rsync.sv
// Reset synchronizer: asynchronous assertion, release after STAGES edges.
// Its output is the only reset seen by the sequencing flops.
module la_rsync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(1);
        end
    end

    assign rst_no = sync_q[STAGES-1];

endmodule

// File: rtl/la_rstseq.sv
// Sequenced reset releaser: N active-low resets released one by one,
// DELAY cycles apart, with a soft re-run that holds all low for HOLD cycles.
(* keep_hierarchy = "yes" *)
module la_rstseq
    import la_rstseq_pkg::*;
#(
    parameter int N      = 4,
    parameter int DELAY  = 16,
    parameter int HOLD   = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         nrst_in,
    input  logic         soft_req,
    output logic [N-1:0] nrst_out,
    output logic         ready,
    output logic         busy
);

    localparam int CW = cnt_width(DELAY, HOLD);

    logic          rst_sync;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] eff;
    logic [N-1:0]  out_q, out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    la_rsync #(
        .STAGES (STAGES)
    ) u_rsync (
        .clk_i  (clk),
        .rst_ni (nrst_in),
        .rst_no (rst_sync)
    );

    // IDLE seen out of reset means E0 already passed: behave as a
    // RELEASE step whose counter was loaded with DELAY-1 at E0.
    assign eff = (state_q == ST_IDLE) ? CW'(DELAY - 1) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE, ST_RELEASE: begin
                busy_d = 1'b1;
                if (eff == '0) begin
                    out_d   = (out_q << 1) | N'(1);
                    cnt_d   = CW'(DELAY - 1);
                    state_d = ST_RELEASE;
                    if (out_d[N-1]) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d   = eff - CW'(1);
                    state_d = ST_RELEASE;
                end
            end
            ST_DONE: begin
                if (soft_req) begin
                    state_d = ST_HOLD;
                    out_d   = '0;
                    cnt_d   = CW'(HOLD - 1);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CW'(DELAY - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign nrst_out = out_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_la_rstseq.sv
// Bench for la_rstseq with N=4, DELAY=3, HOLD=5, STAGES=2.
// Expected values come from the release-timing formulas.
module tb_la_rstseq;

    localparam int N   = 4;
    localparam int DLY = 3;
    localparam int HLD = 5;
    localparam int E0  = 2;

    logic         clk = 1'b0;
    logic         nrst_in = 1'b0;
    logic         soft_req = 1'b0;
    logic [N-1:0] nrst_out;
    logic         ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0] out;
        logic         rdy;
        logic         bsy;
        logic         cb;
    } exp_t;

    typedef struct {
        logic sr;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t tba[16];
    vec_t tbb[20];

    la_rstseq #(
        .N      (N),
        .DELAY  (DLY),
        .HOLD   (HLD),
        .STAGES (2)
    ) dut (
        .clk      (clk),
        .nrst_in  (nrst_in),
        .soft_req (soft_req),
        .nrst_out (nrst_out),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Bits released by edge t when the release reference edge is x.
    function automatic logic [N-1:0] therm(input int t, input int x);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++)
            if (x + DLY * (k + 1) <= t) m[k] = 1'b1;
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".out"}, 32'(nrst_out), 32'(e.out));
            check({tag, ".rdy"}, 32'(ready), 32'(e.rdy));
            if (e.cb) check({tag, ".bsy"}, 32'(busy), 32'(e.bsy));
        end
    endtask

    task automatic step(input logic sr, input exp_t e, input string tag);
        soft_req = sr;
        @(posedge clk);
        sb.push_back(e);
        #1;
        soft_req = 1'b0;
        compare(tag);
    endtask

    task automatic run_a(input int upto, input string nm);
        for (int i = 0; i < upto; i++)
            step(tba[i].sr, tba[i].e, $sformatf("%s[%0d]", nm, i + 1));
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        nrst_in = 1'b1;
    endtask

    initial begin
        logic [N-1:0] prev_out;
        logic         prev_rdy;
        logic         sr;

        for (int t = 1; t <= 16; t++) begin
            tba[t-1].sr     = (t == E0 + 4) || (t == 1);
            tba[t-1].e.out  = therm(t, E0);
            tba[t-1].e.rdy  = &therm(t, E0);
            tba[t-1].e.bsy  = (t > E0) && (t < E0 + N * DLY);
            tba[t-1].e.cb   = (t != E0);
        end
        for (int r = 1; r <= 20; r++) begin
            tbb[r-1].sr     = (r == 1) || (r == 3);
            tbb[r-1].e.out  = therm(r, 1 + HLD);
            tbb[r-1].e.rdy  = &therm(r, 1 + HLD);
            tbb[r-1].e.bsy  = (r < 1 + HLD + N * DLY);
            tbb[r-1].e.cb   = 1'b1;
        end

        // reset held: everything low
        repeat (3) step(1'b0, '{out: '0, rdy: 1'b0, bsy: 1'b0, cb: 1'b1},
                        "reset");

        release_rst();
        run_a(16, "pwrup");

        run_a(0, "none");
        for (int i = 0; i < 20; i++)
            step(tbb[i].sr, tbb[i].e, $sformatf("soft[%0d]", i + 1));

        // mid-sequence reset between edges, no clock edge needed
        release_rst();
        nrst_in = 1'b0;
        #1;
        sb.push_back('{out: '0, rdy: 1'b0, bsy: 1'b0, cb: 1'b1});
        compare("pre_mid");
        nrst_in = 1'b1;
        run_a(E0 + 7, "mid");
        #3;
        nrst_in = 1'b0;
        #1;
        sb.push_back('{out: '0, rdy: 1'b0, bsy: 1'b0, cb: 1'b1});
        compare("async_clr");
        step(1'b0, '{out: '0, rdy: 1'b0, bsy: 1'b0, cb: 1'b1}, "held");
        release_rst();
        run_a(16, "rerun");

        // random soft requests: thermometer shape, falls only via HOLD
        prev_out = nrst_out;
        prev_rdy = ready;
        for (int c = 0; c < 10000; c++) begin
            sr = ($urandom_range(0, 19) == 0);
            soft_req = sr;
            @(posedge clk);
            #1;
            soft_req = 1'b0;
            checks++;
            if ((nrst_out & (nrst_out + 1'b1)) != '0) begin
                errors++;
                $display("FAIL mono c=%0d act=%b req=thermometer", c, nrst_out);
            end
            checks++;
            if ((prev_out & ~nrst_out) != '0 &&
                !(nrst_out == '0 && prev_rdy && sr)) begin
                errors++;
                $display("FAIL fall c=%0d act=%b prev=%b req=no_fall",
                         c, nrst_out, prev_out);
            end
            prev_out = nrst_out;
            prev_rdy = ready;
        end
        repeat (40) @(posedge clk);
        #1;
        check("final.rdy", 32'(ready), 32'(1));
        check("final.out", 32'(nrst_out), 32'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_rstseq.md
LA_RSTSEQ -- requirements
Module: la_rstseq

Interface
REQ-001 The block SHALL expose parameter N, default 4, number of sequenced reset outputs (1..16).
REQ-002 The block SHALL expose parameter DELAY, default 16, cycles between successive releases (>=1).
REQ-003 The block SHALL expose parameter HOLD, default 8, cycles all outputs stay asserted on soft reset (>=1).
REQ-004 The block SHALL expose parameter STAGES, default 2, depth of the internal reset synchronizer.
REQ-005 The block SHALL have port clk, input, 1, single clock.
REQ-006 The block SHALL have port nrst_in, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port soft_req, input, 1, synchronous single-cycle request to re-run the sequence.
REQ-008 The block SHALL have port nrst_out, output, N, active-low resets; bit 0 releases first.
REQ-009 The block SHALL have port ready, output, 1, high when all N outputs are released.
REQ-010 The block SHALL have port busy, output, 1, high while in HOLD or RELEASE.

Function
REQ-011 The block SHALL implement FSM states IDLE, RELEASE, DONE and HOLD.
REQ-012 The block SHALL define E0 as the first rising edge at which the internal synchronized reset is high.
- Its latency from nrst_in deassertion is STAGES edges.
REQ-013 At E0 the FSM SHALL move IDLE->RELEASE and clear the down-counter to DELAY-1.
REQ-014 In RELEASE, nrst_out[k] SHALL rise at edge E0+(k+1)*DELAY, k=0..N-1.
- Bits release one at a time, in ascending index order.
REQ-015 The FSM SHALL enter DONE and drive ready=1 at the same edge nrst_out[N-1] rises.
REQ-016 Once released, a bit SHALL stay high until reset or HOLD; outputs SHALL never glitch.
- Every output is driven directly from a flop.
REQ-017 soft_req in DONE SHALL cause a move to HOLD at the next edge.
- At that edge all nrst_out go low, ready=0, busy=1.
REQ-018 HOLD SHALL last exactly HOLD cycles, then go to RELEASE.
- The release timing of REQ-014 applies with E0 = the HOLD exit edge.
REQ-019 soft_req in IDLE, RELEASE or HOLD SHALL be ignored; no queuing.
REQ-020 The counter width SHALL be $clog2(max(DELAY,HOLD)+1) and SHALL never wrap.
- The counter reloads on each release step.
REQ-021 If nrst_in asserts in any state, the block SHALL go to IDLE immediately.
- All outputs low, whatever the cycle phase.

Reset
REQ-022 While nrst_in=0: nrst_out=0, ready=0, busy=0, state=IDLE, counter=0, asynchronously.
REQ-023 Deassertion of reset SHALL be seen only through the internal synchronizer.
- No flop other than the synchronizer SHALL sample raw nrst_in for release.
REQ-024 Every sequencing flop SHALL use the synchronized reset as its asynchronous clear.

Structure
REQ-025 The FSM state encoding constants SHALL live in shared package la_rstseq_pkg.
REQ-026 The counter-width helper SHALL live in la_rstseq_pkg.
REQ-027 The block SHALL instantiate exactly one sub-module, la_rsync, with STAGES passed through.
- Its output is the internal synchronized reset.
REQ-028 The block SHALL carry keep_hierarchy.

Verification (N=4, DELAY=3, HOLD=5, STAGES=2)
REQ-029 Power-up: release nrst_in -> synchronized reset high at edge 2 (E0).
- nrst_out goes 0001, 0011, 0111, 1111 at E0+3, +6, +9, +12.
- ready=1 at E0+12.
REQ-030 Soft reset: pulse soft_req in DONE -> next edge nrst_out=0000, busy=1.
- HOLD lasts 5 cycles; the bits then re-release every 3 cycles; ready returns 17 cycles after the request edge.
REQ-031 Ignored requests: pulse soft_req at E0+4 and during HOLD -> the sequence timing is unchanged.
- No extra HOLD occurs.
REQ-032 Reset mid-sequence: assert nrst_in at E0+7 between edges -> nrst_out=0000, ready=0, busy=0 with no clock edge.
- After re-release, the full sequence repeats from the start.
REQ-033 Monotonic: random soft_req over 10k cycles -> an assertion checks each bit never rises before its lower bits.
- The assertion also checks no bit falls except via HOLD or reset.
